// File: rtl/axis_bus_arbiter.sv
// Packet-level round-robin arbiter that drives the AXIS bus mux select and steers tready back to the granted FIFO.
// Optional stall watchdog is compiled in when AXIS_ARB_WATCHDOG_EN is defined.
module axis_bus_arbiter #(
    parameter int NUM_CH      = 14,
    parameter int IDX_W       = 4,
    parameter int WDOG_CYCLES = 1024
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              arb_en,
    input  logic [NUM_CH-1:0] ch_req,
    input  logic              m_tvalid,
    input  logic              m_tlast,
    input  logic              m_tready,
    output logic [NUM_CH-1:0] ch_tready,
    output logic [7:0]        bus_sel,
    output logic              grant_valid,
    output logic [IDX_W-1:0]  grant_idx,
    output logic              pkt_done,
    output logic              wdog_err
);
    typedef enum logic {ST_IDLE = 1'b0, ST_GRANT = 1'b1} state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [IDX_W-1:0]    r_rr_ptr;
    logic [IDX_W-1:0]    w_rr_ptr_nxt;
    logic [IDX_W-1:0]    r_grant_idx;
    logic [IDX_W-1:0]    w_grant_idx_nxt;
    logic                r_grant_valid;
    logic                w_grant_valid_nxt;
    logic [7:0]          r_bus_sel;
    logic [7:0]          w_bus_sel_nxt;
    logic                r_pkt_done;
    logic                w_pkt_done_nxt;
    logic                r_wdog_err;
    logic                w_wdog_err_nxt;

    logic                w_beat;
    logic                w_pkt_end;
    logic                w_stall_abort;
    logic [IDX_W-1:0]    w_idx_inc;
    logic [NUM_CH-1:0]   w_grant_onehot;
    logic [NUM_CH-1:0]   w_search_req;
    logic [IDX_W-1:0]    w_search_ptr;
    logic [IDX_W:0]      w_pick;
    logic                w_win_valid;
    logic [IDX_W-1:0]    w_win_idx;

    // First set bit of req searching circularly upward from ptr; MSB of the result flags a hit.
    function automatic logic [IDX_W:0] rr_pick(input logic [NUM_CH-1:0] req, input logic [IDX_W-1:0] ptr);
        logic [IDX_W:0] res;
        int             pos;
        res = '0;
        for (int off = 0; off < NUM_CH; off++) begin
            pos = int'(ptr) + off;
            if (pos >= NUM_CH) begin
                pos = pos - NUM_CH;
            end else begin
                pos = pos;
            end
            if (!res[IDX_W] && req[pos]) begin
                res = {1'b1, pos[IDX_W-1:0]};
            end else begin
                res = res;
            end
        end
        return res;
    endfunction

    assign w_beat         = m_tvalid & m_tready;
    assign w_pkt_end      = (r_state == ST_GRANT) & w_beat & m_tlast;
    assign w_idx_inc      = (r_grant_idx == IDX_W'(NUM_CH - 1)) ? '0 : r_grant_idx + 1'b1;
    assign w_grant_onehot = NUM_CH'(1) << r_grant_idx;

    // The finished channel is masked so every other requester gets a turn first.
    assign w_search_req = (r_state == ST_GRANT) ? (ch_req & ~w_grant_onehot) : ch_req;
    assign w_search_ptr = (r_state == ST_GRANT) ? w_idx_inc : r_rr_ptr;
    assign w_pick       = rr_pick(w_search_req, w_search_ptr);
    assign w_win_valid  = w_pick[IDX_W] | ((r_state == ST_GRANT) & (|(ch_req & w_grant_onehot)));
    assign w_win_idx    = w_pick[IDX_W] ? w_pick[IDX_W-1:0] : r_grant_idx;

`ifdef AXIS_ARB_WATCHDOG_EN
    logic [15:0] r_stall_cnt;

    assign w_stall_abort = (r_state == ST_GRANT) & ~w_beat & (r_stall_cnt == 16'(WDOG_CYCLES - 1));

    // Stall counter: granted cycles since the last beat.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stall_cnt <= 16'd0;
        end else if ((r_state != ST_GRANT) || w_beat || w_stall_abort) begin
            r_stall_cnt <= 16'd0;
        end else begin
            r_stall_cnt <= r_stall_cnt + 16'd1;
        end
    end
`else
    assign w_stall_abort = 1'b0;
`endif

    // Next-state and next-output decode.
    always_comb begin
        w_state_nxt       = r_state;
        w_rr_ptr_nxt      = r_rr_ptr;
        w_grant_idx_nxt   = r_grant_idx;
        w_grant_valid_nxt = r_grant_valid;
        w_bus_sel_nxt     = r_bus_sel;
        w_pkt_done_nxt    = 1'b0;
        w_wdog_err_nxt    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (arb_en && w_win_valid) begin
                    w_state_nxt       = ST_GRANT;
                    w_grant_idx_nxt   = w_win_idx;
                    w_grant_valid_nxt = 1'b1;
                    w_bus_sel_nxt     = 8'd128 + 8'(w_win_idx);
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_GRANT: begin
                if (w_pkt_end) begin
                    w_rr_ptr_nxt   = w_idx_inc;
                    w_pkt_done_nxt = 1'b1;
                    if (arb_en && w_win_valid) begin
                        w_state_nxt       = ST_GRANT;
                        w_grant_idx_nxt   = w_win_idx;
                        w_grant_valid_nxt = 1'b1;
                        w_bus_sel_nxt     = 8'd128 + 8'(w_win_idx);
                    end else begin
                        w_state_nxt       = ST_IDLE;
                        w_grant_idx_nxt   = '0;
                        w_grant_valid_nxt = 1'b0;
                        w_bus_sel_nxt     = 8'd0;
                    end
                end else if (w_stall_abort) begin
                    w_rr_ptr_nxt      = w_idx_inc;
                    w_wdog_err_nxt    = 1'b1;
                    w_state_nxt       = ST_IDLE;
                    w_grant_idx_nxt   = '0;
                    w_grant_valid_nxt = 1'b0;
                    w_bus_sel_nxt     = 8'd0;
                end else begin
                    w_state_nxt = ST_GRANT;
                end
            end
            default: begin
                w_state_nxt       = ST_IDLE;
                w_grant_idx_nxt   = '0;
                w_grant_valid_nxt = 1'b0;
                w_bus_sel_nxt     = 8'd0;
            end
        endcase
    end

    // State and registered output update.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= ST_IDLE;
            r_rr_ptr      <= '0;
            r_grant_idx   <= '0;
            r_grant_valid <= 1'b0;
            r_bus_sel     <= 8'd0;
            r_pkt_done    <= 1'b0;
            r_wdog_err    <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_rr_ptr      <= w_rr_ptr_nxt;
            r_grant_idx   <= w_grant_idx_nxt;
            r_grant_valid <= w_grant_valid_nxt;
            r_bus_sel     <= w_bus_sel_nxt;
            r_pkt_done    <= w_pkt_done_nxt;
            r_wdog_err    <= w_wdog_err_nxt;
        end
    end

    assign ch_tready   = {NUM_CH{r_grant_valid & m_tready}} & w_grant_onehot;
    assign bus_sel     = r_bus_sel;
    assign grant_valid = r_grant_valid;
    assign grant_idx   = r_grant_idx;
    assign pkt_done    = r_pkt_done;
    assign wdog_err    = r_wdog_err;
endmodule
